// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the BTB update controller: controller states and BTB entry field widths.
package bp_update_ctrl_pkg;

  localparam int BTB_IDX_W    = 6;
  localparam int BTB_TAKEN_W  = 1;
  localparam int BTB_TARGET_W = 32;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_IDLE  = 2'd2
  } ctrlState_t;

  // Packed width of one queued update {idx, taken, target} for a given index width.
  function automatic int entryWidth(input int idxW);
    return idxW + BTB_TAKEN_W + BTB_TARGET_W;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue for the BTB update controller: power-of-two FIFO with wrap-around
// pointers and a flush that discards everything queued.
module bp_upd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 39
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      pushData_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [DATA_W-1:0]      headData_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [PTR_W:0]    count_q;
  logic              doPush;
  logic              doPop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign headData_o = mem_q[rdPtr_q];
  assign doPush     = push_i & ~full_o;
  assign doPop      = pop_i & ~empty_o;

  // Pointers wrap for free because DEPTH is a power of two; flush wins over push/pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// BTB update controller: sweeps the BTB clear after reset or on request, then drains
// queued branch-resolution updates into the BTB one write per cycle.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int IDX_W  = BTB_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [IDX_W-1:0]        upd_idx,
  input  logic                    upd_taken,
  input  logic [BTB_TARGET_W-1:0] upd_target,
  input  logic                    inv_req,
  output logic                    inv_done,
  output logic                    busy,
  output logic                    btb_we,
  output logic                    btb_clr,
  output logic [IDX_W-1:0]        btb_idx,
  output logic                    btb_taken,
  output logic [BTB_TARGET_W-1:0] btb_target,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int ENTRY_W = entryWidth(IDX_W);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  ctrlState_t              state_q;
  logic [IDX_W-1:0]        sweepIdx_q;
  logic                    invDone_q;

  logic                    fifoPush;
  logic                    fifoPop;
  logic                    fifoFlush;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [ENTRY_W-1:0]      fifoHead;
  logic [IDX_W-1:0]        headIdx;
  logic                    headTaken;
  logic [BTB_TARGET_W-1:0] headTarget;

  assign busy      = (state_q != ST_IDLE);
  assign upd_ready = (state_q == ST_IDLE) & ~fifoFull & ~inv_req;
  assign inv_done  = invDone_q;
  assign fifoPush  = upd_valid & upd_ready;
  assign fifoPop   = (state_q == ST_IDLE) & ~fifoEmpty;
  assign fifoFlush = (state_q == ST_IDLE) & inv_req;
  assign {headIdx, headTaken, headTarget} = fifoHead;

  bp_upd_fifo #(
    .DEPTH  (QDEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (fifoPush),
    .pushData_i ({upd_idx, upd_taken, upd_target}),
    .pop_i      (fifoPop),
    .flush_i    (fifoFlush),
    .headData_o (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (q_count)
  );

  // A restart request beats sweep completion, so an aborted sweep never reports done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sweepIdx_q <= '0;
      invDone_q  <= 1'b0;
    end else begin
      invDone_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          state_q    <= ST_SWEEP;
          sweepIdx_q <= '0;
        end
        ST_SWEEP: begin
          if (inv_req) begin
            sweepIdx_q <= '0;
          end else if (sweepIdx_q == LAST_IDX) begin
            state_q    <= ST_IDLE;
            sweepIdx_q <= '0;
            invDone_q  <= 1'b1;
          end else begin
            sweepIdx_q <= sweepIdx_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (inv_req) begin
            state_q    <= ST_SWEEP;
            sweepIdx_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_INIT;
          sweepIdx_q <= '0;
        end
      endcase
    end
  end

  // Write port is built only from registered state; idle fields are held at zero.
  always_comb begin
    btb_we     = 1'b0;
    btb_clr    = 1'b0;
    btb_idx    = '0;
    btb_taken  = 1'b0;
    btb_target = '0;
    if (state_q == ST_SWEEP) begin
      btb_we  = 1'b1;
      btb_clr = 1'b1;
      btb_idx = sweepIdx_q;
    end else if ((state_q == ST_IDLE) && !fifoEmpty) begin
      btb_we     = 1'b1;
      btb_idx    = headIdx;
      btb_taken  = headTaken;
      btb_target = headTarget;
    end
  end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, update-queue depth (power of two, >=2).
REQ-002 SHALL have parameter IDX_W, default 6, BTB index width (64 entries).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port upd_valid, input, 1, branch-resolution update offered.
REQ-006 SHALL have port upd_ready, output, 1, update accepted when upd_valid & upd_ready at clk edge.
REQ-007 SHALL have port upd_idx, input, IDX_W, BTB index (pc low bits) of the resolved branch.
REQ-008 SHALL have port upd_taken, input, 1, resolved direction.
REQ-009 SHALL have port upd_target, input, 32, resolved target.
REQ-010 SHALL have port inv_req, input, 1, single-cycle request to invalidate the whole BTB.
REQ-011 SHALL have port inv_done, output, 1, one-cycle pulse when a sweep completes.
REQ-012 SHALL have port busy, output, 1, high in INIT/SWEEP; IF1 suppresses predictions while high.
REQ-013 SHALL have port btb_we, output, 1, BTB write strobe.
REQ-014 SHALL have port btb_clr, output, 1, write clears the valid bit and predictor (else it is an update).
REQ-015 SHALL have ports btb_idx (IDX_W), btb_taken (1), btb_target (32), outputs, write index/data.
REQ-016 SHALL have port q_count, output, log2(QDEPTH)+1, current queue occupancy.

Function
REQ-017 SHALL implement FSM states INIT, SWEEP, IDLE.
REQ-018 INIT SHALL last exactly one cycle, drive no write, then go to SWEEP with sweep index 0.
REQ-019 SWEEP SHALL write one entry per cycle: btb_we=1, btb_clr=1, btb_idx=sweep index, btb_taken=0, btb_target=0; index increments.
REQ-020 A write at index 2^IDX_W-1 SHALL move the FSM to IDLE, and inv_done SHALL pulse in the following cycle (registered).
REQ-021 inv_req in SWEEP SHALL restart the sweep at index 0 on the next cycle; no inv_done for the aborted sweep.
REQ-022 inv_req in IDLE SHALL enter SWEEP at index 0 next cycle and empty the queue on the same edge; queued updates are discarded.
REQ-023 upd_ready SHALL be (state==IDLE) & !full & !inv_req; no enqueue in INIT/SWEEP.
REQ-024 Queue SHALL be a FIFO of {idx, taken, target}, QDEPTH entries, with wrap-around pointers.
REQ-025 In IDLE with the queue non-empty, btb_we=1, btb_clr=0, and btb_* SHALL present the head entry; the head is popped at that edge (one write per cycle).
REQ-026 Latency: an update accepted at edge N SHALL appear on btb_* in cycle N+1 when the queue was empty (no same-cycle bypass).
REQ-027 Simultaneous push and pop SHALL leave q_count unchanged; ready while full is not granted even if popping.
REQ-028 btb_* SHALL be driven only from registered state (no combinational path from upd_* or inv_req to btb_*); when btb_we=0, btb_idx/taken/target/clr SHALL be 0.
REQ-029 The FIFO pop in IDLE and the inv_req queue flush in the same cycle: the pop-write SHALL still occur; the remaining entries are discarded.

Reset
REQ-030 Asserted rst SHALL immediately force state=INIT, sweep index=0, queue empty, inv_done=0.
REQ-031 During reset: btb_we=0, btb_clr=0, upd_ready=0, busy=1, q_count=0, btb_idx/taken/target=0.
REQ-032 Reset mid-sweep or mid-drain SHALL abandon all work; after release, a full sweep from INIT SHALL follow.

Structure
REQ-033 The FSM state encoding, default IDX_W and BTB entry field widths SHALL reside in the shared defs package alongside the BTB field definitions.
REQ-034 The queue SHALL be one sub-module, bp_upd_fifo (push/pop/flush, full/empty/count); the FSM and output muxing stay in bp_update_ctrl.

Verification
REQ-035 Reset release -> cycle 1 INIT no write; cycles 2..65 btb_we=1, btb_clr=1, idx 0..63; cycle 66 inv_done=1, busy=0.
REQ-036 In IDLE push {idx=5, taken=1, target=0x1c000100} -> next cycle btb_we=1, btb_clr=0, idx=5, taken=1, target=0x1c000100; q_count returns to 0.
REQ-037 Push 5 updates on back-to-back cycles, QDEPTH=4 -> all accepted (one drain per cycle), writes in order; hold the drain by asserting inv_req after 4 pushes -> queue empty, sweep starts.
REQ-038 inv_req when the sweep index is 30 -> next write idx=0; exactly one inv_done, 64 cycles after restart.
REQ-039 Async rst asserted mid-edge during a drain with q_count=3 -> outputs zero without a clock; after release, full INIT+SWEEP, q_count=0.
REQ-040 Simultaneous push and pop with q_count=2 -> q_count stays 2, FIFO order preserved across pointer wrap.
